// File: rtl/adder8_3in_arbiter_if.sv
// Bundle of the two requester channels, the result channel and the grant counters.
// slave is the adder/arbiter side, master is the side that drives requests and consumes results.
interface adder8_3in_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req0_c;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] req1_c;
  logic             req1_cin;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH+1:0] res_sum;
  logic             res_id;

  logic [15:0]      grant_cnt0;
  logic [15:0]      grant_cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_c, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_id,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_cin,
    output req1_valid, req1_a, req1_b, req1_c, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_id,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/adder8_3in_arbiter.sv
// Two requesters share one a+b+c+cin adder through a round-robin arbiter feeding a
// single result register; per-requester 16-bit counters track accepted transfers.
module adder8_3in_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  adder8_3in_arbiter_if.slave bus
);

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic [1:0]       w_xfer;
  logic             w_slot_free;
  logic             w_sel;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_op_c;
  logic             w_op_cin;
  logic [WIDTH+1:0] w_sum;

  logic             r_prio;
  logic             r_res_valid;
  logic [WIDTH+1:0] r_res_sum;
  logic             r_res_id;

  assign w_valid     = {bus.req1_valid, bus.req0_valid};
  assign w_slot_free = !r_res_valid || bus.res_ready;

  always_comb begin
    w_grant = 2'b00;
    if (&w_valid) begin
      w_grant[r_prio] = 1'b1;
    end else begin
      w_grant = w_valid;
    end
  end

  // Gating with rst_n keeps both readies low while reset is held, so nothing is
  // accepted before the first clock edge that sees reset released.
  assign w_xfer         = (rst_n && w_slot_free) ? w_grant : 2'b00;
  assign bus.req0_ready = w_xfer[0];
  assign bus.req1_ready = w_xfer[1];

  assign w_sel    = w_grant[1];
  assign w_op_a   = w_sel ? bus.req1_a   : bus.req0_a;
  assign w_op_b   = w_sel ? bus.req1_b   : bus.req0_b;
  assign w_op_c   = w_sel ? bus.req1_c   : bus.req0_c;
  assign w_op_cin = w_sel ? bus.req1_cin : bus.req0_cin;

  // Two guard bits hold the worst case 3*(2^WIDTH-1)+1 exactly.
  assign w_sum = {2'b00, w_op_a} + {2'b00, w_op_b} + {2'b00, w_op_c}
               + {{(WIDTH+1){1'b0}}, w_op_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_id    <= 1'b0;
      r_prio      <= 1'b0;
    end else if (|w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_id    <= w_sel;
      r_prio      <= ~w_sel;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_id    = r_res_id;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_xfer[gi]) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.grant_cnt0 = g_cnt[0].r_cnt;
  assign bus.grant_cnt1 = g_cnt[1].r_cnt;

endmodule

// File: tb/tb_adder8_3in_arbiter.sv
// Bench for adder8_3in_arbiter: a negedge reference model predicts readies and pushes
// expected results into a queue that is popped when the result channel transfers.
module tb_adder8_3in_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder8_3in_arbiter_if #(.WIDTH(W)) bus ();

  adder8_3in_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       id;
    logic [9:0] sum;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   quiet    = 1'b0;

  exp_t        exp_q[$];
  bit          m_valid;
  bit          m_prio;
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;
  bit          m_sf, m_g0, m_g1;
  exp_t        m_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [9:0] add3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic cin);
    return 10'(a) + 10'(b) + 10'(c) + 10'(cin);
  endfunction

  // Reference model, evaluated mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_prio  = 1'b0;
      m_cnt0  = '0;
      m_cnt1  = '0;
      exp_q.delete();
      check_val("rst_res_valid", bus.res_valid, 0);
      check_val("rst_ready0", bus.req0_ready, 0);
      check_val("rst_ready1", bus.req1_ready, 0);
      check_val("rst_cnt0", bus.grant_cnt0, 0);
      check_val("rst_cnt1", bus.grant_cnt1, 0);
    end else begin
      m_sf = !m_valid || bus.res_ready;
      m_g0 = m_sf && bus.req0_valid && (!bus.req1_valid || !m_prio);
      m_g1 = m_sf && bus.req1_valid && (!bus.req0_valid || m_prio);
      check_val("ready0", bus.req0_ready, m_g0);
      check_val("ready1", bus.req1_ready, m_g1);
      check_val("res_valid", bus.res_valid, m_valid);
      check_val("cnt0", bus.grant_cnt0, m_cnt0);
      check_val("cnt1", bus.grant_cnt1, m_cnt1);
      if (m_valid && exp_q.size() > 0) begin
        check_val("res_sum", bus.res_sum, exp_q[0].sum);
        check_val("res_id", bus.res_id, exp_q[0].id);
        if (bus.res_ready) begin
          if (!quiet) $display("result id=%0d sum=%0d", bus.res_id, bus.res_sum);
          void'(exp_q.pop_front());
        end
      end
      if (m_g0 || m_g1) begin
        m_e.id  = m_g1;
        m_e.sum = m_g1 ? add3(bus.req1_a, bus.req1_b, bus.req1_c, bus.req1_cin)
                       : add3(bus.req0_a, bus.req0_b, bus.req0_c, bus.req0_cin);
        exp_q.push_back(m_e);
        m_prio = m_g0;
        if (m_g0) m_cnt0 = m_cnt0 + 16'd1;
        else      m_cnt1 = m_cnt1 + 16'd1;
      end
      m_valid = (m_g0 || m_g1) ? 1'b1 : (bus.res_ready ? 1'b0 : m_valid);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req0(input bit v, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input bit cin);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_cin = cin;
  endtask

  task automatic set_req1(input bit v, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input bit cin);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_cin = cin;
  endtask

  logic [9:0] held_sum;
  logic       held_id;

  initial begin
    set_req0(0, 0, 0, 0, 0);
    set_req1(0, 0, 0, 0, 0);
    bus.res_ready = 1'b0;
    step(2);
    check_val("init_res_valid", bus.res_valid, 0);
    check_val("init_res_sum", bus.res_sum, 0);
    rst_n = 1'b1;

    // Single transfer from requester 0.
    bus.res_ready = 1'b1;
    set_req0(1, 8'd4, 8'd5, 8'd11, 0);
    step(1);
    set_req0(0, 0, 0, 0, 0);
    check_val("single_valid", bus.res_valid, 1);
    check_val("single_sum", bus.res_sum, 20);
    check_val("single_id", bus.res_id, 0);
    check_val("single_cnt0", bus.grant_cnt0, 1);
    step(1);
    check_val("single_drain", bus.res_valid, 0);

    // Only requester 1 for two transfers, then both: requester 0 must win first.
    set_req1(1, 8'd255, 8'd255, 8'd255, 1);
    step(1);
    check_val("ptr_id_a", bus.res_id, 1);
    check_val("ptr_sum_a", bus.res_sum, 766);
    step(1);
    check_val("ptr_id_b", bus.res_id, 1);
    set_req0(1, 8'd15, 8'd3, 8'd200, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_val("cont_valid", bus.res_valid, 1);
      check_val("cont_id", bus.res_id, (i % 2 == 0) ? 0 : 1);
      check_val("cont_sum", bus.res_sum, (i % 2 == 0) ? 218 : 766);
    end

    // Backpressure: result held, no grants, then immediate reload.
    bus.res_ready = 1'b0;
    held_sum = bus.res_sum;
    held_id  = bus.res_id;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_val("bp_sum_hold", bus.res_sum, held_sum);
      check_val("bp_id_hold", bus.res_id, held_id);
      check_val("bp_ready0", bus.req0_ready, 0);
      check_val("bp_ready1", bus.req1_ready, 0);
    end
    bus.res_ready = 1'b1;
    step(1);
    check_val("bp_reload_valid", bus.res_valid, 1);
    check_val("bp_reload_id", bus.res_id, 0);
    check_val("bp_reload_sum", bus.res_sum, 218);

    // Random traffic and backpressure.
    for (int i = 0; i < 60; i++) begin
      set_req0($urandom_range(0, 1), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1));
      set_req1($urandom_range(0, 1), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Reset between edges with a held result and prio pointing at requester 1.
    set_req1(0, 0, 0, 0, 0);
    set_req0(1, 8'd1, 8'd2, 8'd3, 0);
    bus.res_ready = 1'b1;
    step(1);
    bus.res_ready = 1'b0;
    set_req0(0, 0, 0, 0, 0);
    step(1);
    check_val("mid_pre_valid", bus.res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", bus.res_valid, 0);
    check_val("mid_rst_cnt0", bus.grant_cnt0, 0);
    check_val("mid_rst_cnt1", bus.grant_cnt1, 0);
    check_val("mid_rst_sum", bus.res_sum, 0);
    set_req0(1, 8'd10, 8'd20, 8'd30, 1);
    set_req1(1, 8'd7, 8'd7, 8'd7, 0);
    bus.res_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
    check_val("mid_prio_id", bus.res_id, 0);
    check_val("mid_prio_sum", bus.res_sum, 61);

    // Counter wrap on requester 1.
    rst_n = 1'b0;
    set_req0(0, 0, 0, 0, 0);
    set_req1(1, 8'd1, 8'd1, 8'd1, 0);
    step(2);
    rst_n = 1'b1;
    quiet = 1'b1;
    step(65535);
    check_val("wrap_pre", bus.grant_cnt1, 65535);
    step(1);
    check_val("wrap_zero", bus.grant_cnt1, 0);
    quiet = 1'b0;
    set_req1(0, 0, 0, 0, 0);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder8_3in_arbiter.md
ADDER8_3IN_ARBITER -- requirements
Module: adder8_3in_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; result width is WIDTH+2.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 has an operand set pending.
REQ-006 req0_ready  output  1  requester 0 operand set accepted this cycle.
REQ-007 req0_a, req0_b, req0_c  input  WIDTH each  requester 0 operands.
REQ-008 req0_cin  input  1  requester 0 carry-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_cin  same as REQ-005..008 for requester 1.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_ready  input  1  consumer accepts result this cycle.
REQ-012 res_sum  output  WIDTH+2  a+b+c+cin of the granted set.
REQ-013 res_id  output  1  index of the requester that produced res_sum.
REQ-014 grant_cnt0, grant_cnt1  output  16 each  number of accepted transfers per requester.

Function
REQ-015 The block SHALL share one 3-input adder (a+b+c+cin) between the two requesters.
REQ-016 Transfer on requester i: reqi_valid && reqi_ready on a rising clk edge.
REQ-017 Transfer on result: res_valid && res_ready on a rising clk edge.
REQ-018 slot_free = !res_valid || res_ready; no request is granted when slot_free is 0.
REQ-019 reqi_ready SHALL be combinational: slot_free && reqi_valid && grant_i; at most one ready high per cycle.
REQ-020 Arbitration: only one valid -> grant it; both valid -> grant requester indicated by priority pointer prio.
REQ-021 prio SHALL update only on a request transfer, to the index not granted; otherwise it holds.
REQ-022 Latency: res_valid SHALL rise the cycle after a request transfer, with res_sum/res_id from that transfer.
REQ-023 Back-to-back: result transfer and request transfer in the same cycle SHALL load the new result with no bubble (throughput 1/cycle).
REQ-024 res_valid && !res_ready: res_sum, res_id, res_valid SHALL hold stable; both reqi_ready SHALL be 0.
REQ-025 res_valid SHALL fall after a result transfer with no simultaneous request transfer.
REQ-026 res_sum SHALL be exact: max 3*(2^WIDTH-1)+1 fits in WIDTH+2 bits; no truncation, no overflow.
REQ-027 grant_cnti SHALL increment by 1 per requester-i transfer and wrap from 16'hFFFF to 0.
REQ-028 Request inputs are sampled only at transfer; changes while not ready SHALL have no effect.
REQ-029 Implementation ~150-250 lines: arbiter, result register, pointer, counters, adder instance or inline adder.

Reset
REQ-030 rst_n low SHALL asynchronously clear res_valid, res_sum, res_id, prio (=0), grant_cnt0, grant_cnt1.
REQ-031 During reset both reqi_ready SHALL be 0; a result held at reset assertion SHALL be discarded.
REQ-032 After rst_n deasserts, the first request transfer SHALL occur no earlier than the first rising clk edge with rst_n high.

Verification
REQ-033 Single: req0 a=4,b=5,c=11,cin=0, res_ready=1 -> next cycle res_valid=1, res_sum=20, res_id=0, grant_cnt0=1.
REQ-034 Contention: both valid each cycle (req0 15+3+200+0, req1 255+255+255+1), res_ready=1 -> results alternate id 0,1,0,1 with sums 218,766; one result per cycle.
REQ-035 Backpressure: result pending, res_ready=0 for 3 cycles with both valid -> res_sum held, req0_ready=req1_ready=0; on res_ready=1 the next grant loads next cycle with no gap.
REQ-036 Pointer hold: only req1 valid for 2 transfers, then both valid -> req0 granted first (prio=0 after each req1 grant).
REQ-037 Reset mid-operation: res_valid=1, grant_cnt0=5, assert rst_n=0 between edges -> res_valid=0, counters=0 immediately, prio=0.
REQ-038 Wrap: preload 65535 transfers on req1 (or force counter) then one more -> grant_cnt1=0.
